// File: rtl/dm_lsu_pkg.sv
// dm_lsu_pkg: request size codes and FSM state encoding shared by dm_lsu
package dm_lsu_pkg;
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_RSV = 2'b11;
  typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WR, RESP, ERR} state_t;
endpackage

// File: rtl/dm_lsu_if.sv
// dm_lsu_if: req_* handshake and rsp_* completion between MEM stage (master) and dm_lsu (slave)
interface dm_lsu_if #(parameter int ADDR_W = 10);
  logic req_valid, req_ready, req_we, req_signed, rsp_valid, rsp_err;
  logic [1:0] req_size;
  logic [ADDR_W+1:0] req_addr;
  logic [31:0] req_wdata, rsp_rdata;
  modport master(
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    input req_ready, rsp_valid, rsp_rdata, rsp_err
  );
  modport slave(
    input req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dm_lsu_lane.sv
// dm_lsu_lane: combinational lane logic; word/off/size/sgn -> ld (extracted, extended), word/wdata/off/size -> st (merged)
module dm_lsu_lane
  import dm_lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        sgn,
  output logic [31:0] ld,
  output logic [31:0] st
);
  function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] o, input logic [1:0] s, input logic sg);
    logic [7:0] b;
    logic [15:0] h;
    b = w[{o, 3'b000} +: 8];
    h = o[1] ? w[31:16] : w[15:0];
    return s == SZ_B ? {{24{sg & b[7]}}, b} : s == SZ_H ? {{16{sg & h[15]}}, h} : w;
  endfunction
  function automatic logic [31:0] merge(input logic [31:0] w, input logic [31:0] d, input logic [1:0] o, input logic [1:0] s);
    logic [31:0] r;
    r = w;
    if (s == SZ_B) r[{o, 3'b000} +: 8] = d[7:0];
    else if (s == SZ_H) r[{o[1], 4'b0000} +: 16] = d[15:0];
    else r = d;
    return r;
  endfunction
  assign ld = extract(word, off, size, sgn);
  assign st = merge(word, wdata, off, size);
endmodule

// File: rtl/dm_lsu.sv
// dm_lsu: load/store initiator for word-only dm_1k (clk, rst_n, bus: req/rsp slave, dm_*: memory); DM_LSU_ERR_EN enables misaligned/reserved-size errors
module dm_lsu
  import dm_lsu_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  dm_lsu_if.slave           bus,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_din,
  output logic              dm_we,
  input  logic [31:0]       dm_dout
);
  state_t state;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0] off_q, size_q, sz, off;
  logic sgn_q, bad;
  logic [31:0] wbuf, ld, st;
`ifdef DM_LSU_ERR_EN
  assign sz = bus.req_size;
  assign off = bus.req_addr[1:0];
  assign bad = sz == SZ_RSV || (sz == SZ_H && off[0]) || (sz == SZ_W && off != 2'b00);
`else
  assign sz = bus.req_size == SZ_RSV ? SZ_W : bus.req_size;
  assign off = sz == SZ_B ? bus.req_addr[1:0] : sz == SZ_H ? {bus.req_addr[1], 1'b0} : 2'b00;
  assign bad = 1'b0;
`endif
  assign bus.req_ready = state == IDLE;
  assign dm_addr = (state == LOAD || state == RMW_RD || state == WR) ? addr_q : '0;
  assign dm_din = state == WR ? wbuf : '0;
  assign dm_we = state == WR && rst_n;
  dm_lsu_lane u_lane (
    .word(dm_dout),
    .wdata(wbuf),
    .off(off_q),
    .size(size_q),
    .sgn(sgn_q),
    .ld(ld),
    .st(st)
  );
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      addr_q <= '0;
      off_q <= '0;
      size_q <= '0;
      sgn_q <= 1'b0;
      wbuf <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err <= 1'b0;
    end else begin
      bus.rsp_valid <= 1'b0;
      case (state)
        IDLE: if (bus.req_valid) begin
          addr_q <= bus.req_addr[ADDR_W+1:2];
          off_q <= off;
          size_q <= sz;
          sgn_q <= bus.req_signed;
          wbuf <= bus.req_wdata;
          state <= bad ? ERR : !bus.req_we ? LOAD : sz == SZ_W ? WR : RMW_RD;
        end
        LOAD: begin
          bus.rsp_rdata <= ld;
          bus.rsp_err <= 1'b0;
          bus.rsp_valid <= 1'b1;
          state <= RESP;
        end
        RMW_RD: begin
          wbuf <= st;
          state <= WR;
        end
        WR: begin
          bus.rsp_rdata <= '0;
          bus.rsp_err <= 1'b0;
          bus.rsp_valid <= 1'b1;
          state <= RESP;
        end
        ERR: begin
          bus.rsp_rdata <= '0;
          bus.rsp_err <= 1'b1;
          bus.rsp_valid <= 1'b1;
          state <= RESP;
        end
        default: state <= IDLE;
      endcase
    end
endmodule
